key_filter_array: RTL and testbench

Parametrised multi-channel key conditioner for the locker keypad and door-sense inputs. It replaces single-key debouncing with N independent channels, each with:
- an input synchroniser,
- polarity normalisation,
- restart-on-bounce filtering,
- single-cycle press/release event pulses,
- optional long-press detection.

It sits between the raw board pins and the keypad/menu FSMs, which consume only the event pulses and debounced levels.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_chan.sv | 133 +++++++++++++
 rtl/key_filter_array.sv | 60 ++++++
 tb/tb_key_filter_array.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key conditioning channels.
// The optional long-press feature is selected with KEY_LONGPRESS_EN.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_UP,
        KEY_CONF_DN,
        KEY_DOWN,
        KEY_CONF_UP
    } key_state_t;

    // Milliseconds to clock cycles for a given clock frequency.
    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, polarity normalisation, restart-on-bounce
// debounce FSM with registered press/release pulses and, when KEY_LONGPRESS_EN
// is defined, a saturating held counter driving a single long-press pulse.
module key_chan
    import key_pkg::*;
#(
    parameter int DB_CYC     = 4,
    parameter int CW         = 3,
`ifdef KEY_LONGPRESS_EN
    parameter int LONG_CYC   = 10,
`endif
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
`ifdef KEY_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYC);
    logic                     long_done;
`endif

    logic       sync_p0;
    logic       sync_p1;
    logic       s;
    key_state_t state;
    logic [CW-1:0] cnt;

    assign s = sync_p1;

    // Normalise to 1 = pressed and bring the raw pin into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= key_in ^ ACTIVE_LOW;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSM: any disagreement during confirmation restarts from the old level.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= KEY_UP;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_LONGPRESS_EN
            key_long    <= 1'b0;
            long_done   <= 1'b0;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_LONGPRESS_EN
            key_long    <= 1'b0;
`endif
            case (state)
                KEY_UP: begin
                    cnt <= '0;
                    if (s) state <= KEY_CONF_DN;
                end
                KEY_CONF_DN: begin
                    if (!s) begin
                        state <= KEY_UP;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= KEY_DOWN;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                        cnt       <= '0;
`ifdef KEY_LONGPRESS_EN
                        long_done <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                KEY_DOWN: begin
`ifdef KEY_LONGPRESS_EN
                    // One long pulse per accepted press, even if a release bounce restarts the count.
                    if (cnt == LONG_LAST && !long_done) begin
                        key_long  <= 1'b1;
                        long_done <= 1'b1;
                    end
`endif
                    if (!s) begin
                        state <= KEY_CONF_UP;
                        cnt   <= '0;
                    end else begin
`ifdef KEY_LONGPRESS_EN
                        if (cnt != LONG_SAT) cnt <= cnt + ONE;
`else
                        cnt <= '0;
`endif
                    end
                end
                KEY_CONF_UP: begin
                    if (s) begin
                        state <= KEY_DOWN;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= KEY_UP;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= KEY_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef KEY_LONGPRESS_EN
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_filter_array.sv
// N_KEYS independent debounced key channels with press/release/long-press pulses.
// Long-press detection is built only when KEY_LONGPRESS_EN is defined.
module key_filter_array
    import key_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int DB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_LONGPRESS_EN
    localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
    localparam int CNT_MAX  = (LONG_CYC > DB_CYC) ? LONG_CYC : DB_CYC;
`else
    localparam int CNT_MAX  = DB_CYC;
`endif
    localparam int CW       = cnt_width(CNT_MAX);
    localparam bit POL      = (ACTIVE_LOW != 0);

    // Reject configurations the channel FSM cannot honour.
    generate
        if (DB_CYC < 2 || LONG_MS < 0 || N_KEYS < 1 || N_KEYS > 32) begin : g_bad_cfg
            $error("key_filter_array: need DB_CYC >= 2, LONG_MS >= 0, 1 <= N_KEYS <= 32");
        end
    endgenerate

    // One fully independent conditioner per key.
    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
            key_chan #(
                .DB_CYC     (DB_CYC),
                .CW         (CW),
`ifdef KEY_LONGPRESS_EN
                .LONG_CYC   (LONG_CYC),
`endif
                .ACTIVE_LOW (POL)
            ) u_chan (
                .clk         (clk),
                .nrst        (nrst),
                .key_in      (key_in[i]),
                .key_level   (key_level[i]),
                .key_press   (key_press[i]),
                .key_release (key_release[i]),
                .key_long    (key_long[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_filter_array.sv
// Directed bench for key_filter_array with CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10,
// giving DB_CYC=4 and LONG_CYC=10. Inputs change on the falling edge; the following
// rising edge is k=1, the first edge that samples the new level, and an accepted
// change shows on the outputs after edge k=7 (six cycles after sampling).
module tb_key_filter_array;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] key_a;
    logic [3:0] level_a, press_a, release_a, long_a;
    logic [0:0] key_b;
    logic [0:0] level_b, press_b, release_b, long_b;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    key_filter_array #(
        .N_KEYS(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(10), .ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .nrst(nrst), .key_in(key_a),
        .key_level(level_a), .key_press(press_a),
        .key_release(release_a), .key_long(long_a)
    );

    key_filter_array #(
        .N_KEYS(1), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(10), .ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .nrst(nrst), .key_in(key_b),
        .key_level(level_b), .key_press(press_b),
        .key_release(release_b), .key_long(long_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check press/release/level of dut_a at window step k; the event lands at step ev.
    task automatic chk_a(input string tag, input int k, input int ev,
                         input logic [3:0] pe, input logic [3:0] re,
                         input logic [3:0] lb, input logic [3:0] la);
        chk($sformatf("%s_press_k%0d", tag, k),   {28'd0, press_a},   {28'd0, (k == ev) ? pe : 4'b0000});
        chk($sformatf("%s_release_k%0d", tag, k), {28'd0, release_a}, {28'd0, (k == ev) ? re : 4'b0000});
        chk($sformatf("%s_level_k%0d", tag, k),   {28'd0, level_a},   {28'd0, (k >= ev) ? la : lb});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst  = 1'b0;
        key_a = 4'b0000;      // all four keys held down through reset
        key_b = 1'b0;         // active-high key released
        repeat (3) step();

        // Reset state
        chk("rst_level_a",   {28'd0, level_a},   32'd0);
        chk("rst_press_a",   {28'd0, press_a},   32'd0);
        chk("rst_release_a", {28'd0, release_a}, 32'd0);
        chk("rst_long_a",    {28'd0, long_a},    32'd0);
        chk("rst_level_b",   {31'd0, level_b},   32'd0);
        chk("rst_press_b",   {31'd0, press_b},   32'd0);

        // Keys held through reset release are accepted as presses
        @(negedge clk) nrst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_a("rstrel", k, 7, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
            chk($sformatf("rstrel_long_k%0d", k), {28'd0, long_a}, 32'd0);
        end

        // Plain release of key 0
        @(negedge clk) key_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_a("rel0", k, 7, 4'b0000, 4'b0001, 4'b1111, 4'b1110);
        end

        // Bounce on key 0: pressed 3, released 2, then pressed steady from k=6
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk) key_a[0] = (k >= 4 && k <= 5) ? 1'b1 : 1'b0;
            step();
            chk_a("bounce0", k, 12, 4'b0001, 4'b0000, 4'b1110, 4'b1111);
        end

        // Release key 1 with a 2-cycle re-press during confirmation; final rise sampled at k=7
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk) key_a[1] = (k >= 5 && k <= 6) ? 1'b0 : 1'b1;
            step();
            chk_a("rel1", k, 13, 4'b0000, 4'b0010, 4'b1111, 4'b1101);
        end

        // Release key 2 so a fresh press can be timed
        @(negedge clk) key_a[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_a("rel2", k, 7, 4'b0000, 4'b0100, 4'b1101, 4'b1001);
        end

        // Long press on key 2: press at k=7, long 10 cycles later at k=17, no repeat
        @(negedge clk) key_a[2] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk_a("long2", k, 7, 4'b0100, 4'b0000, 4'b1001, 4'b1101);
`ifdef KEY_LONGPRESS_EN
            chk($sformatf("long2_long_k%0d", k), {31'd0, long_a[2]}, {31'd0, (k == 17)});
`else
            chk($sformatf("long2_long_k%0d", k), {31'd0, long_a[2]}, 32'd0);
`endif
        end

        // Release key 2 again
        @(negedge clk) key_a[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_a("rel2b", k, 7, 4'b0000, 4'b0100, 4'b1101, 4'b1001);
        end

        // Release key 0 so it can be pressed alongside the key 3 release
        @(negedge clk) key_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_a("rel0b", k, 7, 4'b0000, 4'b0001, 4'b1001, 4'b1000);
        end

        // Simultaneous: press key 0 and release key 3 on the same edge
        @(negedge clk) key_a = 4'b1110;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_a("simul", k, 7, 4'b0001, 4'b1000, 4'b1000, 4'b0001);
        end

        // Active-high polarity on dut_b
        @(negedge clk) key_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("polb_press_k%0d", k),   {31'd0, press_b},   {31'd0, (k == 7)});
            chk($sformatf("polb_level_k%0d", k),   {31'd0, level_b},   {31'd0, (k >= 7)});
            chk($sformatf("polb_release_k%0d", k), {31'd0, release_b}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
